fluxo_ram_rajada: RTL and testbench

FLUXO_RAM_RAJADA -- requirements
Module: fluxo_ram_rajada

---
 rtl/fluxo_ram_rajada_pkg.sv | 16 +
 rtl/fluxo_ram_rajada_if.sv | 28 ++
 rtl/fluxo_ram_rajada_ram_sp.sv | 23 ++
 rtl/fluxo_ram_rajada.sv | 158 +++++++++++++++
 tb/tb_fluxo_ram_rajada.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/fluxo_ram_rajada_pkg.sv
// Shared types and default geometry for the burst RAM front-end.
package fluxo_ram_pkg;

  localparam int DEF_DATA_W = 9;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 256;

  typedef enum logic [2:0] {
    OCIOSO,
    GRAVA,
    LE,
    DRENA,
    FIM
  } estado_t;

endpackage

// File: rtl/fluxo_ram_rajada_if.sv
// Burst command / data bus between a requester (master) and fluxo_ram_rajada (slave).
interface fluxo_ram_rajada_if #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 8
);
  logic              inicio;
  logic              grava;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   tamanho;
  logic [DATA_W-1:0] dado_entrada;
  logic              entrada_valida;
  logic              pronto_dado;
  logic [DATA_W-1:0] dado_saida;
  logic              saida_valida;
  logic              ocupado;
  logic              fim;
  logic              erro;

  modport master (
    output inicio, grava, base, tamanho, dado_entrada, entrada_valida,
    input  pronto_dado, dado_saida, saida_valida, ocupado, fim, erro
  );

  modport slave (
    input  inicio, grava, base, tamanho, dado_entrada, entrada_valida,
    output pronto_dado, dado_saida, saida_valida, ocupado, fim, erro
  );
endinterface

// File: rtl/fluxo_ram_rajada_ram_sp.sv
// Single-port synchronous RAM, read-first, registered q (1-cycle read latency).
module ram_sp #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    q_o <= mem[addr_i];
  end

endmodule

// File: rtl/fluxo_ram_rajada.sv
// Burst read/write controller over ram_sp. Optional FLUXO_RAM_LIMITE_EN rejects
// bursts with base+tamanho > DEPTH (erro with fim); otherwise addresses wrap mod DEPTH.
module fluxo_ram_rajada
  import fluxo_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  fluxo_ram_rajada_if.slave bus
);

  localparam int              SUM_W = ADDR_W + 2;
  localparam logic [ADDR_W:0] UM    = 1;

  estado_t           state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   tam_q, tam_d;
  logic [ADDR_W:0]   i_q, i_d;
  logic              ultimo;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;
  logic              rd_issue;
  logic              vld_p1_q;
  logic              vld_p2_q;
  logic [DATA_W-1:0] dado_p2_q;
`ifdef FLUXO_RAM_LIMITE_EN
  logic              erro_q, erro_d;
  logic [SUM_W-1:0]  limite;
`endif

  function automatic logic [ADDR_W-1:0] calc_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [ADDR_W:0]   idx);
    logic [SUM_W-1:0] soma;
    soma = SUM_W'(b) + SUM_W'(idx);
    return ADDR_W'(soma % SUM_W'(DEPTH));
  endfunction

  assign ultimo = ((i_q + UM) == tam_q);
`ifdef FLUXO_RAM_LIMITE_EN
  assign limite = SUM_W'(bus.base) + SUM_W'(bus.tamanho);
`endif

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    tam_d    = tam_q;
    i_d      = i_q;
    ram_we   = 1'b0;
    rd_issue = 1'b0;
    ram_addr = calc_addr(base_q, i_q);
`ifdef FLUXO_RAM_LIMITE_EN
    erro_d   = erro_q;
`endif
    unique case (state_q)
      OCIOSO: begin
        if (bus.inicio) begin
          base_d = bus.base;
          tam_d  = bus.tamanho;
          i_d    = '0;
`ifdef FLUXO_RAM_LIMITE_EN
          erro_d = (limite > SUM_W'(DEPTH));
          if (limite > SUM_W'(DEPTH) || bus.tamanho == '0) begin
            state_d = FIM;
          end else begin
            state_d = bus.grava ? GRAVA : LE;
          end
`else
          if (bus.tamanho == '0) begin
            state_d = FIM;
          end else begin
            state_d = bus.grava ? GRAVA : LE;
          end
`endif
        end
      end
      GRAVA: begin
        if (bus.entrada_valida) begin
          ram_we = ~rst;
          i_d    = i_q + UM;
          if (ultimo) state_d = FIM;
        end
      end
      LE: begin
        rd_issue = 1'b1;
        i_d      = i_q + UM;
        if (ultimo) state_d = DRENA;
      end
      DRENA: begin
        // Last word is on dado_saida and nothing left in the RAM stage.
        if (vld_p2_q && !vld_p1_q) state_d = FIM;
      end
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCIOSO;
      i_q     <= '0;
`ifdef FLUXO_RAM_LIMITE_EN
      erro_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
`ifdef FLUXO_RAM_LIMITE_EN
      erro_q  <= erro_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    base_q <= base_d;
    tam_q  <= tam_d;
  end

  ram_sp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(bus.dado_entrada),
    .q_o    (ram_q)
  );

  // p1: RAM q valid; p2: registered output word
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      dado_p2_q <= '0;
    end else begin
      vld_p1_q <= rd_issue;
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) dado_p2_q <= ram_q;
    end
  end

  assign bus.pronto_dado  = (state_q == GRAVA);
  assign bus.dado_saida   = dado_p2_q;
  assign bus.saida_valida = vld_p2_q;
  assign bus.ocupado      = (state_q != OCIOSO);
  assign bus.fim          = (state_q == FIM);
`ifdef FLUXO_RAM_LIMITE_EN
  assign bus.erro         = (state_q == FIM) && erro_q;
`else
  assign bus.erro         = 1'b0;
`endif

endmodule

// File: tb/tb_fluxo_ram_rajada.sv
// Bench for fluxo_ram_rajada: burst table with per-cycle timeline checks and a read-data scoreboard.
module tb_fluxo_ram_rajada;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fluxo_ram_rajada_if #(.DATA_W(9), .ADDR_W(8)) bus ();

  fluxo_ram_rajada #(.DATA_W(9), .ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic            grava;
    logic [7:0]      base;
    logic [8:0]      tam;
    logic [3:0][8:0] dados;
    logic [3:0]      gaps;
    logic [7:0]      esp;
  } burst_t;

  int checks   = 0;
  int failures = 0;
  logic [8:0] sb[$];

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nome, got, exp, $time);
    end
  endtask

  // Read-data scoreboard
  always @(negedge clk) begin
    if (bus.saida_valida === 1'b1) begin
      if (sb.size() == 0) chk("sv_inesperado", 32'(bus.saida_valida), 32'd0);
      else chk("dado_saida", 32'(bus.dado_saida), 32'(sb.pop_front()));
    end
  end

  function automatic burst_t mk(input bit g, input int b, input int t, input int d0, input int d1,
                                input int d2, input int d3, input logic [3:0] gp, input int esp);
    burst_t r;
    r.grava = g;
    r.base  = 8'(b);
    r.tam   = 9'(t);
    r.dados = {9'(d3), 9'(d2), 9'(d1), 9'(d0)};
    r.gaps  = gp;
    r.esp   = 8'(esp);
    return r;
  endfunction

  task automatic run_burst(input burst_t b, input string nome);
    bit   exp_err, wr_ativo, gap_pend;
    int   ciclos, fim_k, w;
    logic [4:0] exp_v, got_v;
`ifdef FLUXO_RAM_LIMITE_EN
    exp_err = (int'(b.base) + int'(b.tam)) > 256;
`else
    exp_err = 1'b0;
`endif
    wr_ativo = b.grava && !exp_err && b.tam != 0;
    ciclos = int'(b.tam);
    for (int j = 0; j < 4; j++) if (j < int'(b.tam) && b.gaps[j]) ciclos++;
    if (exp_err || b.tam == 0) fim_k = 0;
    else if (b.grava)          fim_k = ciclos;
    else                       fim_k = int'(b.tam) + 2;
    if (!b.grava && !exp_err)
      for (int j = 0; j < int'(b.tam); j++) sb.push_back(b.dados[j]);

    bus.inicio  = 1'b1;
    bus.grava   = b.grava;
    bus.base    = b.base;
    bus.tamanho = b.tam;
    @(posedge clk) #1;
    w = 0;
    gap_pend = (b.tam != 0) ? b.gaps[0] : 1'b0;
    for (int k = 0; k <= fim_k + 1; k++) begin
      bus.inicio = (k == int'(b.esp));
      if (k == int'(b.esp)) begin
        bus.grava   = ~b.grava;
        bus.base    = 8'd0;
        bus.tamanho = 9'd0;
      end
      if (wr_ativo && k < ciclos) begin
        if (gap_pend) begin
          bus.entrada_valida = 1'b0;
          gap_pend = 1'b0;
        end else begin
          bus.entrada_valida = 1'b1;
          bus.dado_entrada   = b.dados[w];
          w++;
          gap_pend = (w < int'(b.tam) && w < 4) ? b.gaps[w] : 1'b0;
        end
      end else begin
        bus.entrada_valida = b.grava;
        bus.dado_entrada   = 9'h155;
      end
      @(negedge clk);
      exp_v = {k <= fim_k, k == fim_k, wr_ativo && k < fim_k,
               !b.grava && !exp_err && k >= 2 && k <= int'(b.tam) + 1,
               exp_err && k == fim_k};
      got_v = {bus.ocupado, bus.fim, bus.pronto_dado, bus.saida_valida, bus.erro};
      chk($sformatf("%s k=%0d oc/fim/pr/sv/er", nome, k), 32'(got_v), 32'(exp_v));
      @(posedge clk) #1;
    end
    bus.inicio = 1'b0;
    bus.entrada_valida = 1'b0;
    chk({nome, " sb_vazio"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  burst_t tab [14];

  initial begin
    tab[0]  = mk(1, 10,  4,  1,  2,  3,  4, 4'b1010, -1);
    tab[1]  = mk(0, 10,  4,  1,  2,  3,  4, 4'b0000, -1);
    tab[2]  = mk(1, 10,  0, 99, 99, 99, 99, 4'b0000, -1);
    tab[3]  = mk(0, 10,  0,  0,  0,  0,  0, 4'b0000, -1);
    tab[4]  = mk(0, 10,  4,  1,  2,  3,  4, 4'b0000, -1);
    tab[5]  = mk(1, 252, 4, 20, 21, 22, 23, 4'b0001, -1);
    tab[6]  = mk(1, 0,   2, 30, 31,  0,  0, 4'b0000, -1);
    tab[7]  = mk(1, 254, 4,  7,  8,  9, 10, 4'b0000, -1);
`ifdef FLUXO_RAM_LIMITE_EN
    tab[8]  = mk(0, 252, 4, 20, 21, 22, 23, 4'b0000, -1);
    tab[9]  = mk(0, 0,   2, 30, 31,  0,  0, 4'b0000, -1);
    tab[10] = mk(0, 254, 4,  0,  0,  0,  0, 4'b0000, -1);
    tab[13] = mk(0, 255, 1, 23,  0,  0,  0, 4'b0000, -1);
`else
    tab[8]  = mk(0, 252, 4, 20, 21,  7,  8, 4'b0000, -1);
    tab[9]  = mk(0, 0,   2,  9, 10,  0,  0, 4'b0000, -1);
    tab[10] = mk(0, 254, 4,  7,  8,  9, 10, 4'b0000, -1);
    tab[13] = mk(0, 255, 1,  8,  0,  0,  0, 4'b0000, -1);
`endif
    tab[11] = mk(1, 40,  3, 51, 52, 53,  0, 4'b0000,  1);
    tab[12] = mk(0, 40,  3, 51, 52, 53,  0, 4'b0000,  2);

    bus.inicio = 1'b0; bus.grava = 1'b0; bus.base = '0; bus.tamanho = '0;
    bus.dado_entrada = '0; bus.entrada_valida = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_saidas", 32'({bus.pronto_dado, bus.dado_saida, bus.saida_valida, bus.ocupado,
                             bus.fim, bus.erro}), 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(posedge clk) #1;

    for (int n = 0; n < 14; n++) run_burst(tab[n], $sformatf("b%0d", n));

    // Reset in the second cycle of an 8-word read burst
    bus.inicio = 1'b1; bus.grava = 1'b0; bus.base = 8'd0; bus.tamanho = 9'd8;
    @(posedge clk) #1;
    bus.inicio = 1'b0;
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_meio_saidas", 32'({bus.pronto_dado, bus.dado_saida, bus.saida_valida, bus.ocupado,
                                bus.fim, bus.erro}), 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk) #1;
      @(negedge clk);
      chk($sformatf("pos_rst k=%0d sv/oc", k), 32'({bus.saida_valida, bus.ocupado}), 32'd0);
    end
    @(posedge clk) #1;
    run_burst(tab[1], "pos_rst_leitura");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
